// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory signals around mem_port_arbiter.
// The arbiter uses the slave modport; the caches and memory side use master.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH  = 28,
   parameter int BLOCK_WIDTH = 128
);
   logic                   I_READ;
   logic [ADDR_WIDTH-1:0]  I_ADDRESS;
   logic [BLOCK_WIDTH-1:0] I_READDATA;
   logic                   I_BUSYWAIT;

   logic                   D_READ;
   logic                   D_WRITE;
   logic [ADDR_WIDTH-1:0]  D_ADDRESS;
   logic [BLOCK_WIDTH-1:0] D_WRITEDATA;
   logic [BLOCK_WIDTH-1:0] D_READDATA;
   logic                   D_BUSYWAIT;

   logic                   MEM_READ;
   logic                   MEM_WRITE;
   logic [ADDR_WIDTH-1:0]  MEM_ADDRESS;
   logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA;
   logic [BLOCK_WIDTH-1:0] MEM_READDATA;
   logic                   MEM_BUSYWAIT;

   // Handshake: a requester raises READ/WRITE with address (and data) and holds
   // them until its BUSYWAIT is low; that cycle is the completion cycle and the
   // read data is valid in it. The request drops at the end of that cycle.
   modport slave (
      input  I_READ, I_ADDRESS,
      output I_READDATA, I_BUSYWAIT,
      input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
      output D_READDATA, D_BUSYWAIT,
      output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
      input  MEM_READDATA, MEM_BUSYWAIT
   );

   modport master (
      output I_READ, I_ADDRESS,
      input  I_READDATA, I_BUSYWAIT,
      output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
      input  D_READDATA, D_BUSYWAIT,
      input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
      output MEM_READDATA, MEM_BUSYWAIT
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between I-cache and D-cache misses, one at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on collisions; default is D over I.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 28,
   parameter int BLOCK_WIDTH = 128
) (
   input  logic              CLK,
   input  logic              RESET,
   mem_port_arbiter_if.slave bus,
   output logic [1:0]        dbg_state_o,
   output logic              dbg_started_o
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   started_q, started_d;
   logic                   mem_read_q, mem_read_d;
   logic                   mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic d_req;
   logic serving;
   logic done;
   logic d_wins;

   assign d_req   = bus.D_READ | bus.D_WRITE;
   assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
   // started guards against a stale low MEM_BUSYWAIT before memory reacts
   assign done    = serving && started_q && !bus.MEM_BUSYWAIT;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;  // 0 = I last granted, 1 = D

   assign d_wins = d_req && (!bus.I_READ || !last_grant_q);
`else
   assign d_wins = d_req;
`endif

   always_comb begin
      state_d     = state_q;
      started_d   = started_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (d_wins) begin
               state_d     = SERVE_D;
               started_d   = 1'b0;
               mem_read_d  = bus.D_READ;
               mem_write_d = bus.D_WRITE;
               mem_addr_d  = bus.D_ADDRESS;
               if (bus.D_WRITE) begin
                  mem_wdata_d = bus.D_WRITEDATA;
               end
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = 1'b1;
`endif
            end else if (bus.I_READ) begin
               state_d     = SERVE_I;
               started_d   = 1'b0;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = bus.I_ADDRESS;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = 1'b0;
`endif
            end
         end
         SERVE_I, SERVE_D: begin
            if (bus.MEM_BUSYWAIT) begin
               started_d = 1'b1;
            end
            if (done) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         started_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         started_q   <= started_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Stalls follow the requests while RESET is high so the pipeline stays frozen
   assign bus.I_BUSYWAIT = bus.I_READ & ~(~RESET & (state_q == SERVE_I) & done);
   assign bus.D_BUSYWAIT = d_req & ~(~RESET & (state_q == SERVE_D) & done);

   assign bus.I_READDATA    = bus.MEM_READDATA;
   assign bus.D_READDATA    = bus.MEM_READDATA;
   assign bus.MEM_READ      = mem_read_q;
   assign bus.MEM_WRITE     = mem_write_q;
   assign bus.MEM_ADDRESS   = mem_addr_q;
   assign bus.MEM_WRITEDATA = mem_wdata_q;

   assign dbg_state_o   = state_q;
   assign dbg_started_o = started_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, cache-side drivers, and a
// transaction reference model checking commands, stalls and returned blocks.
module tb_mem_port_arbiter;
   localparam int AW = 28;
   localparam int BW = 128;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       CLK   = 1'b0;
   logic       RESET = 1'b1;
   logic [1:0] dbg_state;
   logic       dbg_started;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .bus          (bus),
      .dbg_state_o  (dbg_state),
      .dbg_started_o(dbg_started)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [BW-1:0] mem_store [logic [AW-1:0]];
   logic [BW-1:0] ref_store [logic [AW-1:0]];

   function automatic logic [BW-1:0] init_pattern(input logic [AW-1:0] a);
      return {a, 4'hA, ~a, 4'h5, a, 4'h3, ~a, 4'hC};
   endfunction

   function automatic logic [BW-1:0] mem_lookup(input logic [AW-1:0] a);
      return mem_store.exists(a) ? mem_store[a] : init_pattern(a);
   endfunction

   function automatic logic [BW-1:0] ref_lookup(input logic [AW-1:0] a);
      return ref_store.exists(a) ? ref_store[a] : init_pattern(a);
   endfunction

   int            fixed_lat = 0;
   logic          mbusy     = 1'b0;
   logic          need_low  = 1'b0;
   int            mcnt      = 0;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_wdata;

   assign bus.MEM_BUSYWAIT = mbusy;

   always @(posedge CLK) begin
      if (RESET) begin
         mbusy    <= 1'b0;
         need_low <= 1'b0;
      end else if (mbusy) begin
         if (mcnt <= 1) begin
            mbusy    <= 1'b0;
            need_low <= 1'b1;
            if (m_wr) mem_store[m_addr] = m_wdata;
            else bus.MEM_READDATA <= mem_lookup(m_addr);
         end else begin
            mcnt <= mcnt - 1;
         end
      end else if (need_low) begin
         if (!(bus.MEM_READ || bus.MEM_WRITE)) need_low <= 1'b0;
      end else if (bus.MEM_READ || bus.MEM_WRITE) begin
         mbusy   <= 1'b1;
         mcnt    <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
         m_wr    <= bus.MEM_WRITE;
         m_addr  <= bus.MEM_ADDRESS;
         m_wdata <= bus.MEM_WRITEDATA;
         bus.MEM_READDATA <= {$urandom, $urandom, $urandom, $urandom};
      end
   end

   // ---------------- reference model / scoreboard ----------------
   typedef enum int {OWN_NONE, OWN_I, OWN_D} own_e;
   own_e          own       = OWN_NONE;
   logic          seen_busy = 1'b0;
   logic          exp_rd    = 1'b0;
   logic          exp_wr    = 1'b0;
   logic [AW-1:0] exp_addr  = '0;
   logic [BW-1:0] exp_wdata = '0;
   logic          last_d    = 1'b0;
   logic          exp_q[$];   // completion order, 1 = D

   always @(negedge CLK) begin : ref_model
      logic done_now;
      logic d_req;
      logic pick_d;
      check_eq("mem_read", bus.MEM_READ, exp_rd);
      check_eq("mem_write", bus.MEM_WRITE, exp_wr);
      check_eq("mem_addr", bus.MEM_ADDRESS, exp_addr);
      check_eq("mem_wdata", bus.MEM_WRITEDATA, exp_wdata);
      done_now = !RESET && (own != OWN_NONE) && seen_busy && !bus.MEM_BUSYWAIT;
      check_eq("i_busy", bus.I_BUSYWAIT, bus.I_READ && !(done_now && own == OWN_I));
      check_eq("d_busy", bus.D_BUSYWAIT,
               (bus.D_READ || bus.D_WRITE) && !(done_now && own == OWN_D));
      if (done_now) begin
         if (own == OWN_I) check_eq("i_rdata", bus.I_READDATA, ref_lookup(exp_addr));
         else if (exp_wr) ref_store[exp_addr] = exp_wdata;
         else check_eq("d_rdata", bus.D_READDATA, ref_lookup(exp_addr));
         exp_q.push_back(own == OWN_D);
      end
      if (RESET) begin
         own = OWN_NONE; seen_busy = 1'b0; last_d = 1'b0;
         exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
      end else if (own == OWN_NONE) begin
         d_req  = bus.D_READ || bus.D_WRITE;
         pick_d = d_req && (!RR || !bus.I_READ || !last_d);
         if (pick_d) begin
            own = OWN_D; seen_busy = 1'b0; last_d = 1'b1;
            exp_rd = bus.D_READ; exp_wr = bus.D_WRITE; exp_addr = bus.D_ADDRESS;
            if (bus.D_WRITE) exp_wdata = bus.D_WRITEDATA;
         end else if (bus.I_READ) begin
            own = OWN_I; seen_busy = 1'b0; last_d = 1'b0;
            exp_rd = 1'b1; exp_wr = 1'b0; exp_addr = bus.I_ADDRESS;
         end
      end else if (done_now) begin
         own = OWN_NONE; exp_rd = 1'b0; exp_wr = 1'b0;
      end else if (bus.MEM_BUSYWAIT) begin
         seen_busy = 1'b1;
      end
   end

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic i_access(input logic [AW-1:0] a, output int lat, output logic [BW-1:0] data);
      bit ok = 1'b0;
      lat = 0;
      bus.I_READ = 1'b1; bus.I_ADDRESS = a;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (!bus.I_BUSYWAIT) begin ok = 1'b1; break; end
         lat++;
      end
      if (!ok) check_eq("i_timeout", bus.I_BUSYWAIT, 1'b0);
      data = bus.I_READDATA;
      @(posedge CLK); #1;
      bus.I_READ = 1'b0;
   endtask

   task automatic d_access(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                           output int lat, output logic [BW-1:0] data);
      bit ok = 1'b0;
      lat = 0;
      bus.D_READ = !wr; bus.D_WRITE = wr; bus.D_ADDRESS = a; bus.D_WRITEDATA = wd;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (!bus.D_BUSYWAIT) begin ok = 1'b1; break; end
         lat++;
      end
      if (!ok) check_eq("d_timeout", bus.D_BUSYWAIT, 1'b0);
      data = bus.D_READDATA;
      @(posedge CLK); #1;
      bus.D_READ = 1'b0; bus.D_WRITE = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   localparam logic [BW-1:0] BLK_I = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [BW-1:0] BLK_D = {4{32'h11111111}};

   initial begin
      int            li, ld;
      logic [BW-1:0] di, dd;
      bit            rst_seen;
      bus.I_READ = 1'b0; bus.I_ADDRESS = '0;
      bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_ADDRESS = '0; bus.D_WRITEDATA = '0;
      fixed_lat = 4;
      mem_store[28'h40] = BLK_I;
      ref_store[28'h40] = BLK_I;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_state", dbg_state, 2'd0);
      check_eq("rst_started", dbg_started, 1'b0);
      @(posedge CLK); #1;
      RESET = 1'b0;

      // single I miss
      i_access(28'h40, li, di);
      check_eq("i_single_lat", li, 6);
      check_eq("i_single_data", di, BLK_I);

      // D write-back
      d_access(1'b1, 28'h100, BLK_D, ld, dd);
      check_eq("d_wb_lat", ld, 6);
      check_eq("d_wb_store", mem_lookup(28'h100), BLK_D);

      // collisions, twice
      for (int k = 0; k < 2; k++) begin
         exp_q.delete();
         fork
            i_access(28'h200 + 28'(k * 16), li, di);
            d_access(1'b0, 28'h300 + 28'(k * 16), '0, ld, dd);
         join
         check_eq("coll_count", exp_q.size(), 2);
         if (exp_q.size() > 0) check_eq("coll_first_d", exp_q[0], !RR);
         check_eq("coll_i_lat", li, RR ? 6 : 13);
         check_eq("coll_d_lat", ld, RR ? 13 : 6);
      end

      // back-to-back: D arrives during I service
      fork
         i_access(28'h400, li, di);
         begin
            repeat (2) @(posedge CLK);
            #1;
            d_access(1'b1, 28'h500, {$urandom, $urandom, $urandom, $urandom}, ld, dd);
         end
      join
      check_eq("b2b_i_lat", li, 6);
      check_eq("b2b_d_lat", ld, 11);

      // reset while serving I with memory busy
      rst_seen = 1'b0;
      fork
         i_access(28'h600, li, di);
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge CLK);
               if (bus.MEM_BUSYWAIT) begin rst_seen = 1'b1; break; end
            end
            check_eq("rst_mem_busy_seen", rst_seen, 1'b1);
            @(posedge CLK); #1;
            RESET = 1'b1;
            @(negedge CLK);
            check_eq("rst_ibusy_during", bus.I_BUSYWAIT, 1'b1);
            @(posedge CLK); #1;
            RESET = 1'b0;
            @(negedge CLK);
            check_eq("rst_state_after", dbg_state, 2'd0);
            check_eq("rst_mem_read_after", bus.MEM_READ, 1'b0);
            check_eq("rst_ibusy_after", bus.I_BUSYWAIT, 1'b1);
         end
      join
      check_eq("rst_reissue_lat", li, 10);
      check_eq("rst_reissue_data", di, init_pattern(28'h600));

      // idle
      @(posedge CLK); #1;
      repeat (20) @(negedge CLK);
      check_eq("idle_addr", bus.MEM_ADDRESS, 28'h600);
      check_eq("idle_busy", {bus.I_BUSYWAIT, bus.D_BUSYWAIT}, 2'b00);
      @(posedge CLK); #1;

      // randomized traffic from both caches
      fixed_lat = 0;
      fork
         for (int n = 0; n < 30; n++) begin
            int            l;
            logic [BW-1:0] d;
            int            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge CLK);
            if (gap != 0) #1;
            i_access(28'($urandom_range(0, 15) * 16), l, d);
         end
         for (int n = 0; n < 30; n++) begin
            int            l;
            logic [BW-1:0] d;
            int            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge CLK);
            if (gap != 0) #1;
            d_access(1'($urandom_range(0, 1)), 28'($urandom_range(0, 15) * 16),
                     {$urandom, $urandom, $urandom, $urandom}, l, d);
         end
      join

      repeat (3) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
